rtl_bigreg_writer: RTL and testbench

RTL_BIGREG_WRITER -- requirements
Module: rtl_bigreg_writer

---
 rtl/mem_layout_pkg.sv | 24 ++
 rtl/rtl_bigreg_writer.sv | 164 ++++++++++++++++
 tb/tb_rtl_bigreg_writer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_layout_pkg.sv
// Shared memory-map layout constants and the big-register writer state type.
package mem_layout_pkg;

  // Memory-map geometry seen by the PS.
  localparam int unsigned MemSize  = 256;
  localparam int unsigned MemIdW   = $clog2(MemSize);
  localparam int unsigned BusWidth = 32;

  // Buffer timestamp: a wide RTL register published as consecutive narrow entries.
  localparam int unsigned BufTsWidth       = 32;
  localparam int unsigned BufTsSampleWidth = 16;
  localparam int unsigned BufTsBaseId      = 27;
  localparam int unsigned BufTsSamples     = BufTsWidth / BufTsSampleWidth;
  localparam int unsigned BufTsValidId     = BufTsBaseId + BufTsSamples;

  typedef enum logic [2:0] {
    StIdle,
    StWrSample,
    StWrValid,
    StWaitAck,
    StWrClear
  } bigreg_state_e;

endpackage

// File: rtl/rtl_bigreg_writer.sv
// Publishes a wide register into the mem map as SAMPLES narrow entries, then
// raises a valid flag, waits for the PS to read it and clears it again. A
// one-deep pending slot absorbs a value arriving mid-sequence; further values
// are dropped and counted.
module rtl_bigreg_writer
  import mem_layout_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = BufTsWidth,
  parameter int unsigned SAMPLE_WIDTH = BufTsSampleWidth,
  parameter int unsigned BASE_ID      = BufTsBaseId
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic [MemIdW-1:0]     wr_id,
  output logic [BusWidth-1:0]   wr_data,
  output logic                  wr_en,
  input  logic                  wr_ready,
  input  logic                  valid_read,
  output logic                  busy,
  output logic                  pending,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned SAMPLES  = DATA_WIDTH / SAMPLE_WIDTH;
  localparam int unsigned VALID_ID = BASE_ID + SAMPLES;
  localparam int unsigned IdxW     = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  // Zero-extended slice i of a wide value, LSB slice at i = 0.
  function automatic logic [BusWidth-1:0] slice_of(input logic [DATA_WIDTH-1:0] v,
                                                   input int unsigned i);
    logic [DATA_WIDTH-1:0] sh;
    sh = v >> (i * SAMPLE_WIDTH);
    return BusWidth'(sh[SAMPLE_WIDTH-1:0]);
  endfunction

  bigreg_state_e         state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] active_q, active_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [MemIdW-1:0]     wr_id_q, wr_id_d;
  logic [BusWidth-1:0]   wr_data_q, wr_data_d;
  logic                  hs;

  assign hs = wr_en_q & wr_ready;

  // Next state, registered-output preload and pending/drop bookkeeping.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    active_d     = active_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    drop_cnt_d   = drop_cnt_q;
    wr_en_d      = wr_en_q;
    wr_id_d      = wr_id_q;
    wr_data_d    = wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          // Pending value goes first; a simultaneous strobe refills the slot.
          active_d     = pend_data_q;
          pend_valid_d = data_in_valid;
          if (data_in_valid) pend_data_d = data_in;
          idx_d     = '0;
          state_d   = StWrSample;
          wr_en_d   = 1'b1;
          wr_id_d   = MemIdW'(BASE_ID);
          wr_data_d = slice_of(pend_data_q, 0);
        end else if (data_in_valid) begin
          active_d  = data_in;
          idx_d     = '0;
          state_d   = StWrSample;
          wr_en_d   = 1'b1;
          wr_id_d   = MemIdW'(BASE_ID);
          wr_data_d = slice_of(data_in, 0);
        end
      end
      StWrSample: begin
        if (hs) begin
          if (32'(idx_q) == SAMPLES - 1) begin
            idx_d     = '0;
            state_d   = StWrValid;
            wr_id_d   = MemIdW'(VALID_ID);
            wr_data_d = BusWidth'(1);
          end else begin
            idx_d     = IdxW'(32'(idx_q) + 1);
            wr_id_d   = MemIdW'(BASE_ID + 32'(idx_q) + 1);
            wr_data_d = slice_of(active_q, 32'(idx_q) + 1);
          end
        end
      end
      StWrValid: begin
        if (hs) begin
          state_d = StWaitAck;
          wr_en_d = 1'b0;
        end
      end
      StWaitAck: begin
        if (valid_read) begin
          state_d   = StWrClear;
          wr_en_d   = 1'b1;
          wr_id_d   = MemIdW'(VALID_ID);
          wr_data_d = '0;
        end
      end
      StWrClear: begin
        if (hs) begin
          state_d = StIdle;
          wr_en_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outside IDLE (including the cycle leaving WR_CLEAR) new values queue or drop.
    if (state_q != StIdle && data_in_valid) begin
      if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_data_d  = data_in;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  // State and output registers; reset abandons any partial write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      active_q     <= '0;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      drop_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_id_q      <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      drop_cnt_q   <= drop_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_id_q      <= wr_id_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_id    = wr_id_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != StIdle);
  assign pending  = pend_valid_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_rtl_bigreg_writer.sv
// Bench for rtl_bigreg_writer: directed scenarios plus random traffic, all
// checked against a job-level model (expected write list, pending slot, drops).
module tb_rtl_bigreg_writer;

  localparam int unsigned Base    = 27;
  localparam int unsigned Samples = 2;
  localparam int unsigned SampW   = 16;
  localparam int unsigned ValidId = Base + Samples;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        wr_ready = 1'b1;
  logic        valid_read = 1'b0;
  logic [7:0]  wr_id;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        busy;
  logic        pending;
  logic [15:0] drop_cnt;

  rtl_bigreg_writer dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .wr_id        (wr_id),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_ready     (wr_ready),
    .valid_read   (valid_read),
    .busy         (busy),
    .pending      (pending),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: outstanding writes as {id, data}, plus job-level flags.
  logic [39:0] exp_q[$];
  bit          m_busy, m_waiting, m_pend;
  logic [31:0] m_pend_data;
  logic [15:0] m_drops;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic m_reset();
    exp_q.delete();
    m_busy = 0; m_waiting = 0; m_pend = 0; m_pend_data = '0; m_drops = '0;
  endtask

  // A published value becomes its slices in ascending id order, then the flag.
  task automatic m_start(input logic [31:0] v);
    logic [31:0] sh;
    for (int i = 0; i < Samples; i++) begin
      sh = v >> (i * SampW);
      exp_q.push_back({8'(Base + i), 32'(sh[SampW-1:0])});
    end
    exp_q.push_back({8'(ValidId), 32'd1});
    m_busy = 1;
  endtask

  // One clock: update the model with this cycle's inputs, advance, then compare.
  task automatic step(input bit quiet);
    bit          hs;
    logic        pen;
    logic [7:0]  pid;
    logic [31:0] pdata;
    logic [39:0] e;
    hs    = (wr_en === 1'b1) && wr_ready;
    pen   = wr_en;
    pid   = wr_id;
    pdata = wr_data;
    if (rst) begin
      m_reset();
    end else begin
      if (!m_busy) begin
        if (m_pend) begin
          m_start(m_pend_data);
          m_pend = data_in_valid;
          if (data_in_valid) m_pend_data = data_in;
        end else if (data_in_valid) begin
          m_start(data_in);
        end
      end else begin
        if (data_in_valid) begin
          if (!m_pend) begin
            m_pend = 1; m_pend_data = data_in;
          end else if (m_drops != 16'hFFFF) begin
            m_drops = m_drops + 16'd1;
          end
        end
        if (m_waiting && valid_read) begin
          exp_q.push_back({8'(ValidId), 32'd0});
          m_waiting = 0;
        end
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_id", {24'd0, pid}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_id", {24'd0, pid}, {24'd0, e[39:32]});
          check("wr_data", pdata, e[31:0]);
          if (e == {8'(ValidId), 32'd1}) m_waiting = 1;
          if (e == {8'(ValidId), 32'd0}) m_busy = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (!quiet) begin
      if (pen === 1'b1 && !hs && !rst) begin
        check("hold_en", {31'd0, wr_en}, 32'd1);
        check("hold_id", {24'd0, wr_id}, {24'd0, pid});
        check("hold_data", wr_data, pdata);
      end
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("pending", {31'd0, pending}, {31'd0, m_pend});
      check("drop_cnt", {16'd0, drop_cnt}, {16'd0, m_drops});
    end
  endtask

  // Run the current work to completion, acknowledging the flag when raised.
  task automatic drain();
    int n = 0;
    data_in_valid = 0;
    wr_ready = 1;
    while ((m_busy || m_pend) && n < 60) begin
      valid_read = m_waiting;
      step(0);
      n++;
    end
    valid_read = 0;
    check("drain_busy", {31'd0, busy}, 32'd0);
    check("drain_pending", {31'd0, pending}, 32'd0);
  endtask

  initial begin
    m_reset();
    // Reset state
    rst = 1; step(0); step(0);
    rst = 0;
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_id", {24'd0, wr_id}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);

    // Basic sequence with wr_ready high
    data_in = 32'hDEAD_BEEF; data_in_valid = 1; step(0);
    data_in_valid = 0;
    check("first_wr_en", {31'd0, wr_en}, 32'd1);
    check("first_wr_id", {24'd0, wr_id}, 32'd27);
    check("first_wr_data", wr_data, 32'h0000_BEEF);
    step(0); step(0);
    check("valid_wr_id", {24'd0, wr_id}, 32'd29);
    step(0);
    check("waitack_wr_en", {31'd0, wr_en}, 32'd0);
    step(0); step(0);
    check("waitack_ignores", {31'd0, wr_en}, 32'd0);
    valid_read = 1; step(0); valid_read = 0;
    check("clear_wr_id", {24'd0, wr_id}, 32'd29);
    check("clear_wr_data", wr_data, 32'd0);
    step(0);
    check("busy_falls", {31'd0, busy}, 32'd0);

    // Backpressure on the ID 28 write
    data_in = 32'hA5A5_3C3C; data_in_valid = 1; step(0);
    data_in_valid = 0; step(0);
    check("bp_id28", {24'd0, wr_id}, 32'd28);
    wr_ready = 0;
    for (int i = 0; i < 3; i++) step(0);
    check("bp_held_data", wr_data, 32'h0000_A5A5);
    wr_ready = 1;
    drain();

    // Value arriving during WAIT_ACK queues and follows
    data_in = 32'hCAFE_F00D; data_in_valid = 1; step(0);
    data_in_valid = 0; step(0); step(0); step(0);
    data_in = 32'h1234_5678; data_in_valid = 1; step(0);
    data_in_valid = 0;
    check("queued_pending", {31'd0, pending}, 32'd1);
    valid_read = 1; step(0); valid_read = 0;
    step(0);
    step(0);
    check("second_id", {24'd0, wr_id}, 32'd27);
    check("second_data", wr_data, 32'h0000_5678);
    step(0); step(0); step(0);

    // Drops while the pending slot is full, then saturation
    data_in = 32'h1111_2222; data_in_valid = 1; step(0);
    data_in = 32'h3333_4444; step(0);
    check("drop_one", {16'd0, drop_cnt}, 32'd1);
    for (int i = 0; i < 32'h10000; i++) begin
      data_in = $urandom;
      step(1);
    end
    data_in_valid = 0;
    step(0);
    check("drop_sat", {16'd0, drop_cnt}, 32'h0000_FFFF);
    drain();

    // Reset during the ID 27 write
    data_in = 32'h0BAD_CAFE; data_in_valid = 1; step(0);
    data_in_valid = 0; wr_ready = 0;
    rst = 1; step(0); rst = 0;
    check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("mid_rst_wr_id", {24'd0, wr_id}, 32'd0);
    check("mid_rst_wr_data", wr_data, 32'd0);
    check("mid_rst_drops", {16'd0, drop_cnt}, 32'd0);
    wr_ready = 1;
    data_in = 32'h7777_9999; data_in_valid = 1; step(0);
    data_in_valid = 0;
    check("restart_id", {24'd0, wr_id}, 32'd27);
    check("restart_data", wr_data, 32'h0000_9999);
    drain();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      data_in       = $urandom;
      data_in_valid = ($urandom_range(0, 9) == 0);
      wr_ready      = ($urandom_range(0, 9) < 7);
      valid_read    = ($urandom_range(0, 7) == 0);
      rst           = ($urandom_range(0, 499) == 0);
      step(0);
    end
    rst = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
